ebpc_znz_decoder: RTL and testbench



---
 rtl/ebpc_pkg.sv | 13 +
 rtl/ebpc_znz_bit_buffer.sv | 62 ++++++
 rtl/ebpc_znz_decoder.sv | 165 ++++++++++++++++
 tb/tb_ebpc_znz_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ebpc_pkg.sv
// Shared constants and types for the EBPC codec blocks.
package ebpc_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ZRL_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ZEROS
  } znz_dec_state_t;

endpackage

// File: rtl/ebpc_znz_bit_buffer.sv
// MSB-aligned 2*DATA_W bit buffer for the ZNZ decoder: word append and n-bit consume.
// EBPC_ZNZ_DEC_ERR_CHECK_EN adds rest_nz_o (any bits left after this cycle's consume).
module ebpc_znz_bit_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ZRL_W  = 4,
  parameter int unsigned CNT_W  = $clog2(2*DATA_W+1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic [CNT_W-1:0]  consume_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              top_bit_o,
`ifdef EBPC_ZNZ_DEC_ERR_CHECK_EN
  output logic              rest_nz_o,
`endif
  output logic [ZRL_W-1:0]  run_o
);

  localparam int unsigned BUF_W = 2*DATA_W;

  logic [BUF_W-1:0] bits_q, bits_d, shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_left;

  // Bits below cnt_q are always zero, so a new word can be OR-ed in right
  // after the bits that survive this cycle's consume.
  always_comb begin
    shifted  = bits_q << consume_i;
    cnt_left = cnt_q - consume_i;
    bits_d   = shifted;
    cnt_d    = cnt_left;
    if (load_i) begin
      bits_d = shifted | ({word_i, {DATA_W{1'b0}}} >> cnt_left);
      cnt_d  = cnt_left + CNT_W'(DATA_W);
    end
    if (clr_i) begin
      bits_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bits_q <= '0;
      cnt_q  <= '0;
    end else begin
      bits_q <= bits_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign top_bit_o = bits_q[BUF_W-1];
  assign run_o     = bits_q[BUF_W-2 -: ZRL_W];

`ifdef EBPC_ZNZ_DEC_ERR_CHECK_EN
  assign rest_nz_o = |shifted;
`endif

endmodule

// File: rtl/ebpc_znz_decoder.sv
// Rebuilds the word stream from the ZNZ run-length bitstream and decoded non-zero values.
// EBPC_ZNZ_DEC_ERR_CHECK_EN enables the sticky err_o (clipped run / nonzero padding).
module ebpc_znz_decoder #(
  parameter int unsigned DATA_W = ebpc_pkg::DATA_W,
  parameter int unsigned ZRL_W  = ebpc_pkg::ZRL_W,
  parameter int unsigned LEN_W  = 24
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              len_vld_i,
  output logic              len_rdy_o,
  input  logic [DATA_W-1:0] znz_data_i,
  input  logic              znz_vld_i,
  output logic              znz_rdy_o,
  input  logic [DATA_W-1:0] nz_data_i,
  input  logic              nz_vld_i,
  output logic              nz_rdy_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic              err_o
);
  import ebpc_pkg::*;

  localparam int unsigned CNT_W = $clog2(2*DATA_W+1);

  znz_dec_state_t    state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [ZRL_W-1:0]  zcnt_q, zcnt_d;
  logic              buf_clr, buf_load, buf_top;
  logic [CNT_W-1:0]  buf_consume, buf_cnt;
  logic [ZRL_W-1:0]  buf_run;
  logic              slot_free, sym_complete;
  logic              out_load, out_last;
  logic [DATA_W-1:0] out_data;
`ifdef EBPC_ZNZ_DEC_ERR_CHECK_EN
  logic              buf_rest_nz, err_set, err_q;
`endif

  assign buf_load = znz_vld_i && znz_rdy_o;

  ebpc_znz_bit_buffer #(
    .DATA_W (DATA_W),
    .ZRL_W  (ZRL_W),
    .CNT_W  (CNT_W)
  ) u_bit_buffer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (buf_clr),
    .load_i    (buf_load),
    .word_i    (znz_data_i),
    .consume_i (buf_consume),
    .cnt_o     (buf_cnt),
    .top_bit_o (buf_top),
`ifdef EBPC_ZNZ_DEC_ERR_CHECK_EN
    .rest_nz_o (buf_rest_nz),
`endif
    .run_o     (buf_run)
  );

  assign slot_free    = !vld_o || rdy_i;
  assign sym_complete = ((buf_cnt >= CNT_W'(1)) && buf_top) ||
                        ((buf_cnt >= CNT_W'(ZRL_W+1)) && !buf_top);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    zcnt_d      = zcnt_q;
    len_rdy_o   = 1'b0;
    znz_rdy_o   = 1'b0;
    nz_rdy_o    = 1'b0;
    buf_clr     = 1'b0;
    buf_consume = '0;
    out_load    = 1'b0;
    out_last    = 1'b0;
    out_data    = '0;
    unique case (state_q)
      IDLE: begin
        len_rdy_o = 1'b1;
        if (len_vld_i) begin
          remaining_d = len_i;
          buf_clr     = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        // Fetch only to finish the current symbol, so no word past the block end is taken.
        znz_rdy_o = !sym_complete && (buf_cnt <= CNT_W'(DATA_W));
        if (sym_complete && buf_top) begin
          nz_rdy_o = slot_free;
          if (nz_vld_i && slot_free) begin
            out_load    = 1'b1;
            out_data    = nz_data_i;
            out_last    = (remaining_q == '0);
            buf_consume = CNT_W'(1);
            if (out_last) begin
              buf_clr = 1'b1;
              state_d = IDLE;
            end else begin
              remaining_d = remaining_q - LEN_W'(1);
            end
          end
        end else if (sym_complete) begin
          buf_consume = CNT_W'(ZRL_W+1);
          zcnt_d      = buf_run;
          state_d     = ZEROS;
        end
      end
      ZEROS: begin
        if (slot_free) begin
          out_load = 1'b1;
          out_last = (remaining_q == '0);
          if (out_last) begin
            buf_clr = 1'b1;
            state_d = IDLE;
          end else begin
            remaining_d = remaining_q - LEN_W'(1);
            if (zcnt_q == '0) state_d = RUN;
            else              zcnt_d  = zcnt_q - ZRL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      zcnt_q      <= '0;
      vld_o       <= 1'b0;
      data_o      <= '0;
      last_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      zcnt_q      <= zcnt_d;
      if (out_load) begin
        vld_o  <= 1'b1;
        data_o <= out_data;
        last_o <= out_last;
      end else if (rdy_i) begin
        vld_o  <= 1'b0;
      end
    end
  end

`ifdef EBPC_ZNZ_DEC_ERR_CHECK_EN
  assign err_set = out_load && out_last &&
                   (buf_rest_nz || ((state_q == ZEROS) && (zcnt_q != '0)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_q | err_set;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ebpc_znz_decoder.sv
// Self-checking bench for ebpc_znz_decoder (DATA_W=8, ZRL_W=4): vector table plus scoreboard.
module tb_ebpc_znz_decoder;

  localparam int unsigned LIM = 2000;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [23:0] len_i;
  logic        len_vld_i, len_rdy_o;
  logic [7:0]  znz_data_i;
  logic        znz_vld_i, znz_rdy_o;
  logic [7:0]  nz_data_i;
  logic        nz_vld_i, nz_rdy_o;
  logic [7:0]  data_o;
  logic        last_o, vld_o, rdy_i, err_o;

  always #5 clk = ~clk;

  ebpc_znz_decoder #(
    .DATA_W (8),
    .ZRL_W  (4),
    .LEN_W  (24)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .len_i      (len_i),
    .len_vld_i  (len_vld_i),
    .len_rdy_o  (len_rdy_o),
    .znz_data_i (znz_data_i),
    .znz_vld_i  (znz_vld_i),
    .znz_rdy_o  (znz_rdy_o),
    .nz_data_i  (nz_data_i),
    .nz_vld_i   (nz_vld_i),
    .nz_rdy_o   (nz_rdy_o),
    .data_o     (data_o),
    .last_o     (last_o),
    .vld_o      (vld_o),
    .rdy_i      (rdy_i),
    .err_o      (err_o)
  );

  // Byte lists are right-aligned: element k of n is at [8*(n-1-k) +: 8].
  typedef struct {
    logic [23:0]  len;
    int           n_znz;
    logic [23:0]  znz_v;
    int           n_nz;
    logic [63:0]  nz_v;
    int           n_exp;
    logic [159:0] exp_v;
  } vec_t;

  vec_t       vecs[7];
  logic [8:0] sb[$];
  int         znz_at_len[$];
  int         n_vec = 0, n_fail = 0;
  int         cyc = 0, znz_hs = 0, popped = 0, stall_cnt = 0;
  int         first_znz_cyc = -1, first_vld_cyc = -1;
  logic       nz_rdy_seen = 1'b0, gaps_en = 1'b0;
  int         rdy_mode = 0;
  logic       stalled_prev = 1'b0;
  logic [8:0] held = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: handshake timed out after %0d cycles, expected ready", name, LIM);
  endtask

  always @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 0)      rdy_i = 1'b1;
    else if (rdy_mode == 1) rdy_i = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (len_vld_i && len_rdy_o) znz_at_len.push_back(znz_hs);
    if (znz_vld_i && znz_rdy_o) begin
      znz_hs++;
      if (first_znz_cyc < 0) first_znz_cyc = cyc;
    end
    if (nz_rdy_o) nz_rdy_seen = 1'b1;
    if (vld_o && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (stalled_prev) chk("hold", {vld_o, last_o, data_o}, {1'b1, held});
    if (vld_o && !rdy_i) stall_cnt++;
    if (vld_o && rdy_i) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL extra_out: got %0h with last=%0b, expected no output", data_o, last_o);
      end else begin
        chk("out", {last_o, data_o}, sb.pop_front());
        popped++;
      end
    end
    stalled_prev = vld_o && !rdy_i;
    held         = {last_o, data_o};
  end

  task automatic gap();
    if (gaps_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic drive_len(input logic [23:0] v);
    int t = 0;
    gap();
    len_i = v; len_vld_i = 1'b1;
    @(negedge clk);
    while (!len_rdy_o && t < LIM) begin @(negedge clk); t++; end
    if (!len_rdy_o) timeout_fail("len_hs");
    @(posedge clk); #1;
    len_vld_i = 1'b0;
  endtask

  task automatic drive_znz(input logic [7:0] v);
    int t = 0;
    gap();
    znz_data_i = v; znz_vld_i = 1'b1;
    @(negedge clk);
    while (!znz_rdy_o && t < LIM) begin @(negedge clk); t++; end
    if (!znz_rdy_o) timeout_fail("znz_hs");
    @(posedge clk); #1;
    znz_vld_i = 1'b0;
  endtask

  task automatic drive_nz(input logic [7:0] v);
    int t = 0;
    gap();
    nz_data_i = v; nz_vld_i = 1'b1;
    @(negedge clk);
    while (!nz_rdy_o && t < LIM) begin @(negedge clk); t++; end
    if (!nz_rdy_o) timeout_fail("nz_hs");
    @(posedge clk); #1;
    nz_vld_i = 1'b0;
  endtask

  // Runs vector a, then vector b back to back when b >= 0.
  task automatic run_blocks(input int a, input int b);
    logic [23:0] lq[$];
    logic [7:0]  zq[$], nq[$];
    int          ids[$];
    int          tot_z = 0, t = 0;
    vec_t        v;
    ids.push_back(a);
    if (b >= 0) ids.push_back(b);
    foreach (ids[i]) begin
      v = vecs[ids[i]];
      lq.push_back(v.len);
      for (int k = 0; k < v.n_znz; k++) zq.push_back(v.znz_v[8*(v.n_znz-1-k) +: 8]);
      for (int k = 0; k < v.n_nz; k++)  nq.push_back(v.nz_v[8*(v.n_nz-1-k) +: 8]);
      for (int k = 0; k < v.n_exp; k++)
        sb.push_back({(k == v.n_exp-1), v.exp_v[8*(v.n_exp-1-k) +: 8]});
      tot_z += v.n_znz;
    end
    znz_hs = 0; first_znz_cyc = -1; first_vld_cyc = -1; nz_rdy_seen = 1'b0;
    znz_at_len.delete();
    fork
      foreach (lq[i]) drive_len(lq[i]);
      foreach (zq[i]) drive_znz(zq[i]);
      foreach (nq[i]) drive_nz(nq[i]);
    join
    while (sb.size() != 0 && t < LIM) begin @(posedge clk); t++; end
    #1;
    chk("drain", sb.size(), 0);
    sb.delete();
    chk("znz_count", znz_hs, tot_z);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{24'd3,  1, 24'hF0,     4, 64'h11223344,         4,  160'h11223344};
    vecs[1] = '{24'd15, 1, 24'h78,     0, 64'h0,                16, 160'h0};
    vecs[2] = '{24'd5,  1, 24'h8B,     3, 64'hA1B2C3,           6,  160'hA1_00_00_00_B2_C3};
    vecs[3] = '{24'd9,  3, 24'hE1C180, 7, 64'h01020304050607,   10, 160'h01_02_03_00_00_04_05_00_06_07};
    vecs[4] = '{24'd18, 2, 24'hFEA8,   8, 64'h1011121314151617, 19,
                160'h10_11_12_13_14_15_16_00_00_00_00_00_00_00_00_00_00_00_17};
    vecs[5] = '{24'd0,  1, 24'h00,     0, 64'h0,                1,  160'h0};
    vecs[6] = '{24'd1,  1, 24'h18,     0, 64'h0,                2,  160'h0};

    rst_ni = 1'b0; rdy_i = 1'b1;
    len_i = '0; len_vld_i = 1'b0; znz_data_i = '0; znz_vld_i = 1'b0;
    nz_data_i = '0; nz_vld_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", {vld_o, last_o, data_o, err_o}, '0);
    chk("rst_rdy", {len_rdy_o, znz_rdy_o, nz_rdy_o}, 3'b100);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_blocks(i, -1);
      if (i == 0) chk("latency", first_vld_cyc - first_znz_cyc, 2);
      if (i == 1) chk("nz_rdy_idle", nz_rdy_seen, 0);
    end

    rdy_mode = 2; rdy_i = 1'b1; stall_cnt = 0; popped = 0;
    fork
      run_blocks(4, -1);
      begin
        int t = 0;
        while (popped < 4 && t < LIM) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        rdy_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rdy_i = 1'b1;
      end
    join
    chk("stall_cycles", stall_cnt, 5);

    rdy_mode = 1; gaps_en = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 5; i++) run_blocks(i, -1);

    rdy_mode = 0; gaps_en = 1'b0;
    run_blocks(0, 5);
    chk("b2b_lens", znz_at_len.size(), 2);
    if (znz_at_len.size() == 2) begin
      chk("b2b_znz_at_len0", znz_at_len[0], 0);
      chk("b2b_znz_at_len1", znz_at_len[1], 1);
    end

    chk("err_clean", err_o, 0);
    run_blocks(6, -1);
    for (int k = 0; k < 3; k++) begin
`ifdef EBPC_ZNZ_DEC_ERR_CHECK_EN
      chk("err_clip", err_o, 1);
`else
      chk("err_clip", err_o, 0);
`endif
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
